// File: rtl/avmm_cmd_master_pkg.sv
// -----------------------------------------------------------------------------
// avmm_pkg
// Shared types and constants for the Avalon-MM command master.
//   state_t        : master FSM states (IDLE, BUS, RLAT, RESP)
//   DEF_ADDR_W     : default word-address width
//   DEF_DATA_W     : default data width
//   RSP_WRITE_DATA : value returned in rsp_readdata for writes and timeouts
// -----------------------------------------------------------------------------
package avmm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RLAT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int DEF_ADDR_W     = 3;
  localparam int DEF_DATA_W     = 32;
  localparam int RSP_WRITE_DATA = 0;

endpackage

// File: rtl/avmm_cmd_master_if.sv
// -----------------------------------------------------------------------------
// avmm_cmd_master_if
// Bundles the command port, the response port and the Avalon-MM master bus of
// avmm_cmd_master.
//   modport master : the command master's view (drives cmd_ready, rsp_*, avm_*
//                    strobes/fields; samples cmd_*, rsp_ready, avm_readdata,
//                    avm_waitrequest)
//   modport slave  : the opposite view, used by whatever sits around the master
//                    (command source, response sink and bus target)
// Parameters: ADDR_W (word address width), DATA_W (data width, byteenable is
// DATA_W/8 bits).
// -----------------------------------------------------------------------------
interface avmm_cmd_master_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // command port
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [DATA_W-1:0] cmd_writedata;
  logic [BE_W-1:0]   cmd_byteenable;

  // response port
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_readdata;
  logic              rsp_error;

  // Avalon-MM master bus
  logic [ADDR_W-1:0] avm_address;
  logic [BE_W-1:0]   avm_byteenable;
  logic [DATA_W-1:0] avm_writedata;
  logic              avm_write;
  logic              avm_read;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_waitrequest;

  modport master (
    input  cmd_valid, cmd_write, cmd_address, cmd_writedata, cmd_byteenable,
    input  rsp_ready, avm_readdata, avm_waitrequest,
    output cmd_ready, rsp_valid, rsp_readdata, rsp_error,
    output avm_address, avm_byteenable, avm_writedata, avm_write, avm_read
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address, cmd_writedata, cmd_byteenable,
    output rsp_ready, avm_readdata, avm_waitrequest,
    input  cmd_ready, rsp_valid, rsp_readdata, rsp_error,
    input  avm_address, avm_byteenable, avm_writedata, avm_write, avm_read
  );

endinterface

// File: rtl/avmm_cmd_master.sv
// -----------------------------------------------------------------------------
// avmm_cmd_master
// Single-outstanding Avalon-MM master. Takes one command on a valid/ready
// command port, issues one read or write on the avm_ bus (honouring
// waitrequest), collects read data after a fixed READ_LATENCY and hands back a
// response word on a valid/ready response port. Used by bring-up sequencers in
// place of a CPU.
//
// Ports:
//   rsi_MRST_reset : asynchronous, active-high reset
//   csi_MCLK_clk   : clock
//   bus            : avmm_cmd_master_if.master (cmd_*, rsp_*, avm_*)
//
// Parameters:
//   ADDR_W, DATA_W  : bus widths (byteenable is DATA_W/8)
//   READ_LATENCY    : cycles from read acceptance to valid readdata, 1..7
//   TIMEOUT_CYCLES  : waitrequest-high limit, only used with AVM_TIMEOUT_EN
//
// Build option:
//   AVM_TIMEOUT_EN  : when defined, a stalled bus phase is abandoned after
//                     TIMEOUT_CYCLES waitrequest-high cycles and answered with
//                     rsp_error=1. When undefined the master waits forever and
//                     rsp_error is constant 0.
// -----------------------------------------------------------------------------
module avmm_cmd_master
  import avmm_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic               rsi_MRST_reset,
  input logic               csi_MCLK_clk,
  avmm_cmd_master_if.master bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int LAT_W = 3;

  if (READ_LATENCY < 1 || READ_LATENCY > 7 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("avmm_cmd_master: READ_LATENCY must be 1..7 and TIMEOUT_CYCLES >= 1");
  end

  state_t            r_state;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_readdata;
  logic [ADDR_W-1:0] r_avm_address;
  logic [BE_W-1:0]   r_avm_byteenable;
  logic [DATA_W-1:0] r_avm_writedata;
  logic              r_avm_write;
  logic              r_avm_read;
  logic [LAT_W-1:0]  r_lat_cnt;

`ifdef AVM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_rsp_error;
`endif

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_state          <= IDLE;
      r_cmd_ready      <= 1'b0;
      r_rsp_valid      <= 1'b0;
      r_rsp_readdata   <= '0;
      r_avm_address    <= '0;
      r_avm_byteenable <= '0;
      r_avm_writedata  <= '0;
      r_avm_write      <= 1'b0;
      r_avm_read       <= 1'b0;
      r_lat_cnt        <= '0;
`ifdef AVM_TIMEOUT_EN
      r_to_cnt         <= '0;
      r_rsp_error      <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          // cmd_ready is registered: it comes up one cycle after reset
          // release or after a response handshake.
          r_cmd_ready <= 1'b1;
          if (bus.cmd_valid && r_cmd_ready) begin
            r_cmd_ready      <= 1'b0;
            r_avm_address    <= bus.cmd_address;
            r_avm_byteenable <= bus.cmd_byteenable;
            r_avm_writedata  <= bus.cmd_writedata;
            r_avm_write      <= bus.cmd_write;
            r_avm_read       <= ~bus.cmd_write;
`ifdef AVM_TIMEOUT_EN
            r_to_cnt         <= '0;
`endif
            r_state          <= BUS;
          end
        end

        BUS: begin
          // Acceptance wins over the timeout on the cycle the limit is hit.
          if (!bus.avm_waitrequest) begin
            r_avm_write <= 1'b0;
            r_avm_read  <= 1'b0;
            if (r_avm_write) begin
              r_rsp_readdata <= DATA_W'(RSP_WRITE_DATA);
`ifdef AVM_TIMEOUT_EN
              r_rsp_error    <= 1'b0;
`endif
              r_rsp_valid    <= 1'b1;
              r_state        <= RESP;
            end else begin
              r_lat_cnt <= LAT_W'(READ_LATENCY - 1);
              r_state   <= RLAT;
            end
          end
`ifdef AVM_TIMEOUT_EN
          else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            // This is the TIMEOUT_CYCLES-th stalled cycle: give up.
            r_avm_write    <= 1'b0;
            r_avm_read     <= 1'b0;
            r_rsp_readdata <= DATA_W'(RSP_WRITE_DATA);
            r_rsp_error    <= 1'b1;
            r_rsp_valid    <= 1'b1;
            r_state        <= RESP;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
`endif
        end

        RLAT: begin
          // avm_readdata is only looked at on the final latency cycle.
          if (r_lat_cnt == '0) begin
            r_rsp_readdata <= bus.avm_readdata;
`ifdef AVM_TIMEOUT_EN
            r_rsp_error    <= 1'b0;
`endif
            r_rsp_valid    <= 1'b1;
            r_state        <= RESP;
          end else begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready      = r_cmd_ready;
  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_readdata   = r_rsp_readdata;
  assign bus.avm_address    = r_avm_address;
  assign bus.avm_byteenable = r_avm_byteenable;
  assign bus.avm_writedata  = r_avm_writedata;
  assign bus.avm_write      = r_avm_write;
  assign bus.avm_read       = r_avm_read;
`ifdef AVM_TIMEOUT_EN
  assign bus.rsp_error      = r_rsp_error;
`else
  assign bus.rsp_error      = 1'b0;
`endif

endmodule
